// File: rtl/err_inj_pkg.sv
// rtl/err_inj_pkg.sv - shared types and defaults for the error-injection campaign controller
package err_inj_pkg;

    localparam int NCH_DEF = 64;
    localparam int CW_DEF  = 16;

    typedef logic [CW_DEF-1:0] phase_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_INJECT,
        ST_SETTLE,
        ST_SELECT,
        ST_DUMP,
        ST_FIN
    } state_e;

    // Next timed phase after cur, skipping any phase whose count is zero.
    function automatic state_e phase_after(state_e cur, logic dly_nz, logic dur_nz, logic stl_nz);
        state_e nxt;
        nxt = ST_SELECT;
        case (cur)
            ST_IDLE:   nxt = dly_nz ? ST_DELAY : (dur_nz ? ST_INJECT : (stl_nz ? ST_SETTLE : ST_SELECT));
            ST_DELAY:  nxt = dur_nz ? ST_INJECT : (stl_nz ? ST_SETTLE : ST_SELECT);
            ST_INJECT: nxt = stl_nz ? ST_SETTLE : ST_SELECT;
            default:   nxt = ST_SELECT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/err_campaign_ctrl_if.sv
// rtl/err_campaign_ctrl_if.sv - scan-chain dump bus between the controller and the chains
interface err_campaign_ctrl_if #(
    parameter int NCH = 64
);
    localparam int IW = $clog2(NCH);

    logic [NCH-1:0] dump_en;
    logic [NCH-1:0] ch_out;
    logic [NCH-1:0] ch_out_vld;
    logic [NCH-1:0] ch_out_done;
    logic           dump_bit;
    logic [IW-1:0]  dump_ch;
    logic           dump_vld;

    modport master (
        output dump_en, dump_bit, dump_ch, dump_vld,
        input  ch_out, ch_out_vld, ch_out_done
    );

    modport slave (
        input  dump_en, dump_bit, dump_ch, dump_vld,
        output ch_out, ch_out_vld, ch_out_done
    );

endinterface

// File: rtl/err_pri_enc.sv
// rtl/err_pri_enc.sv - combinational lowest-set-bit finder
module err_pri_enc #(
    parameter int N = 64,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  in_vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top so the last hit written is the lowest set bit.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/err_campaign_ctrl.sv
// rtl/err_campaign_ctrl.sv - sequences delay/inject/settle phases then dumps selected scan chains
module err_campaign_ctrl
    import err_inj_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    localparam int IW = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          cfg_mode,
    input  logic [CW-1:0]       cfg_delay,
    input  logic [CW-1:0]       cfg_dur,
    input  logic [CW-1:0]       cfg_settle,
    input  logic [NCH-1:0]      cfg_mask,
    output logic                err_en,
    output logic [1:0]          err_ctrl,
    output logic                c_en,
    output logic                busy,
    output logic                done,
    err_campaign_ctrl_if.master dbus
);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   dly_q, dly_d;
    logic [CW-1:0]   dur_q, dur_d;
    logic [CW-1:0]   stl_q, stl_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            dvld_q, dvld_d;
    logic            dbit_q, dbit_d;
    logic [IW-1:0]   dch_q, dch_d;

    logic [CW-1:0]   src_dly, src_dur, src_stl, ph_load;
    state_e          ph_next;
    logic [IW-1:0]   enc_idx;
    logic            enc_any;

    err_pri_enc #(.N(NCH)) u_pri_enc (
        .in_vec (mask_q),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    // A phase is entered with count-1 so it lasts exactly count cycles.
    function automatic logic [CW-1:0] load_for(state_e s, logic [CW-1:0] ld, logic [CW-1:0] lu,
                                               logic [CW-1:0] ls);
        case (s)
            ST_DELAY:  return ld - CW'(1);
            ST_INJECT: return lu - CW'(1);
            ST_SETTLE: return ls - CW'(1);
            default:   return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dly_d   = dly_q;
        dur_d   = dur_q;
        stl_d   = stl_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        dvld_d  = 1'b0;
        dbit_d  = 1'b0;
        dch_d   = '0;
        src_dly = dly_q;
        src_dur = dur_q;
        src_stl = stl_q;
        if (state_q == ST_IDLE) begin
            src_dly = cfg_delay;
            src_dur = cfg_dur;
            src_stl = cfg_settle;
        end
        ph_next = phase_after(state_q, |src_dly, |src_dur, |src_stl);
        ph_load = load_for(ph_next, src_dly, src_dur, src_stl);

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d  = cfg_mode;
                        dly_d   = cfg_delay;
                        dur_d   = cfg_dur;
                        stl_d   = cfg_settle;
                        mask_d  = cfg_mask;
                        state_d = ph_next;
                        cnt_d   = ph_load;
                    end
                end
                ST_DELAY, ST_INJECT, ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ph_next;
                        cnt_d   = ph_load;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_SELECT: begin
                    if (enc_any) begin
                        idx_d   = enc_idx;
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
                ST_DUMP: begin
                    // A bit arriving with done is still emitted before leaving.
                    if (dbus.ch_out_vld[idx_q]) begin
                        dvld_d = 1'b1;
                        dbit_d = dbus.ch_out[idx_q];
                        dch_d  = idx_q;
                    end
                    if (dbus.ch_out_done[idx_q]) begin
                        mask_d[idx_q] = 1'b0;
                        state_d       = ST_SELECT;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dly_q   <= '0;
            dur_q   <= '0;
            stl_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            dvld_q  <= 1'b0;
            dbit_q  <= 1'b0;
            dch_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dly_q   <= dly_d;
            dur_q   <= dur_d;
            stl_q   <= stl_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            dvld_q  <= dvld_d;
            dbit_q  <= dbit_d;
            dch_q   <= dch_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign c_en          = (state_q == ST_DELAY) || (state_q == ST_INJECT) || (state_q == ST_SETTLE);
    assign err_en        = (state_q == ST_INJECT);
    assign err_ctrl      = err_en ? mode_q : 2'b00;
    assign dbus.dump_en  = (state_q == ST_DUMP) ? (NCH'(1) << idx_q) : '0;
    assign dbus.dump_vld = dvld_q;
    assign dbus.dump_bit = dbit_q;
    assign dbus.dump_ch  = dch_q;

endmodule

// File: tb/tb_err_campaign_ctrl.sv
// tb/tb_err_campaign_ctrl.sv - randomized self-checking bench for err_campaign_ctrl
module tb_err_campaign_ctrl;
    import err_inj_pkg::*;

    localparam int NCH   = 64;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cfg_mode = '0;
    phase_cnt_t cfg_delay = '0, cfg_dur = '0, cfg_settle = '0;
    logic [63:0] cfg_mask = '0;
    logic       err_en, c_en, busy, done;
    logic [1:0] err_ctrl;

    err_campaign_ctrl_if #(.NCH(NCH)) dbus ();

    err_campaign_ctrl #(.NCH(NCH), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_mode   (cfg_mode),
        .cfg_delay  (cfg_delay),
        .cfg_dur    (cfg_dur),
        .cfg_settle (cfg_settle),
        .cfg_mask   (cfg_mask),
        .err_en     (err_en),
        .err_ctrl   (err_ctrl),
        .c_en       (c_en),
        .busy       (busy),
        .done       (done),
        .dbus       (dbus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          len_a [64];
    logic [7:0]  bits_a[64];
    bit          tog_a [64];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_chains();
        for (int k = 0; k < 64; k++) begin
            len_a[k]  = 0;
            bits_a[k] = '0;
            tog_a[k]  = 1'b0;
        end
        dbus.ch_out      = '0;
        dbus.ch_out_vld  = '0;
        dbus.ch_out_done = '0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        obs = {err_en, err_ctrl, c_en, busy, done, dbus.dump_en != 0, dbus.dump_vld,
               dbus.dump_bit, dbus.dump_ch != 0};
        checks++;
        if (obs !== 10'b0) begin
            $display("FAIL reset_outputs got %b want 0", obs);
            errors++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_release_idle busy=%b done=%b want 0 0", busy, done);
            errors++;
        end
    endtask

    // Expected trace built from the phase rules: d DELAY, i INJECT, s SETTLE, SELECT, FIN.
    task automatic test_phases(input int d, input int i, input int s, input logic [1:0] mode,
                               input bit perturb);
        logic [6:0] exp_q[$];
        logic [6:0] obs;
        int ncen, nerr;
        ncen = 0;
        nerr = 0;
        for (int k = 0; k < d; k++) exp_q.push_back(7'b1010000);
        for (int k = 0; k < i; k++) exp_q.push_back({4'b1011, mode, 1'b0});
        for (int k = 0; k < s; k++) exp_q.push_back(7'b1010000);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b1100000);
        cfg_delay  = phase_cnt_t'(d);
        cfg_dur    = phase_cnt_t'(i);
        cfg_settle = phase_cnt_t'(s);
        cfg_mode   = mode;
        cfg_mask   = '0;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            obs = {busy, done, c_en, err_en, err_ctrl, dbus.dump_en != 0};
            if (c_en === 1'b1) ncen++;
            if (err_en === 1'b1) nerr++;
            checks++;
            if (obs !== exp_q[j]) begin
                $display("FAIL phase_trace d=%0d i=%0d s=%0d cyc=%0d got %b want %b",
                         d, i, s, j, obs, exp_q[j]);
                errors++;
            end
            if (perturb && j < exp_q.size() - 1) begin
                start      = 1'($urandom_range(1));
                cfg_delay  = phase_cnt_t'($urandom_range(9));
                cfg_dur    = phase_cnt_t'($urandom_range(9));
                cfg_settle = phase_cnt_t'($urandom_range(9));
                cfg_mode   = 2'($urandom_range(3));
                cfg_mask   = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL phase_end_idle busy=%b done=%b want 0 0", busy, done);
            errors++;
        end
        checks++;
        if (ncen != d + i + s || nerr != i) begin
            $display("FAIL phase_counts c_en=%0d err_en=%0d want %0d %0d", ncen, nerr, d + i + s, i);
            errors++;
        end
        cfg_mask = '0;
    endtask

    // Runs one campaign, playing the role of the chains, and scoreboards the merged stream.
    task automatic run_campaign(input int d, input int i, input int s, input logic [1:0] mode,
                                input logic [63:0] mask, input bit gaps);
        int exp_ch[$];
        bit exp_bit[$];
        int pos[64];
        bit dsent[64];
        int ncyc, ncen, nerr, ndone, post, c, lowest;
        bit first_seen;
        logic [63:0] post_en, cur_en;
        ncyc = 0; ncen = 0; nerr = 0; ndone = 0; post = 0; first_seen = 1'b0;
        post_en = '0; lowest = -1;
        for (int k = 63; k >= 0; k--) if (mask[k]) lowest = k;
        for (int k = 0; k < 64; k++) begin
            pos[k] = 0;
            dsent[k] = 1'b0;
            if (mask[k]) begin
                for (int b = 0; b < len_a[k]; b++) begin
                    exp_ch.push_back(k);
                    exp_bit.push_back(bits_a[k][b]);
                end
            end
        end
        cfg_delay  = phase_cnt_t'(d);
        cfg_dur    = phase_cnt_t'(i);
        cfg_settle = phase_cnt_t'(s);
        cfg_mode   = mode;
        cfg_mask   = mask;
        start      = 1'b1;
        step();
        start = 1'b0;
        while (1) begin
            if (dbus.dump_vld === 1'b1) begin
                checks++;
                if (exp_ch.size() == 0) begin
                    $display("FAIL stream_extra ch=%0d bit=%b want no more bits", dbus.dump_ch, dbus.dump_bit);
                    errors++;
                end else begin
                    if (dbus.dump_ch !== 6'(exp_ch[0]) || dbus.dump_bit !== exp_bit[0]) begin
                        $display("FAIL stream_bit got ch=%0d bit=%b want ch=%0d bit=%b",
                                 dbus.dump_ch, dbus.dump_bit, exp_ch[0], exp_bit[0]);
                        errors++;
                    end
                    void'(exp_ch.pop_front());
                    void'(exp_bit.pop_front());
                end
            end
            checks++;
            if (!$onehot0(dbus.dump_en)) begin
                $display("FAIL dump_en_onehot got %h want at most one bit", dbus.dump_en);
                errors++;
            end
            if (!first_seen && dbus.dump_en != 0) begin
                first_seen = 1'b1;
                checks++;
                if (ncyc != d + i + s + 1 || dbus.dump_en !== (64'd1 << lowest)) begin
                    $display("FAIL first_select cyc=%0d en=%h want cyc=%0d en=%h",
                             ncyc, dbus.dump_en, d + i + s + 1, 64'd1 << lowest);
                    errors++;
                end
            end
            if (c_en === 1'b1) ncen++;
            if (err_en === 1'b1) begin
                nerr++;
                checks++;
                if (err_ctrl !== mode) begin
                    $display("FAIL err_ctrl got %0d want %0d", err_ctrl, mode);
                    errors++;
                end
            end
            if (post == 2) begin
                checks++;
                if (dbus.dump_en !== '0 || busy !== 1'b1 || done !== 1'b0) begin
                    $display("FAIL after_done_select en=%h busy=%b done=%b want 0 1 0",
                             dbus.dump_en, busy, done);
                    errors++;
                end
                post = 1;
            end else if (post == 1) begin
                checks++;
                if (post_en != 0) begin
                    if (dbus.dump_en !== post_en) begin
                        $display("FAIL next_chain got %h want %h", dbus.dump_en, post_en);
                        errors++;
                    end
                end else if (done !== 1'b1 || dbus.dump_en !== '0) begin
                    $display("FAIL final_done done=%b en=%h want 1 0", done, dbus.dump_en);
                    errors++;
                end
                post = 0;
            end
            if (done === 1'b1) ndone++;
            if (ndone > 0 || ncyc >= LIMIT) break;
            cur_en           = dbus.dump_en;
            dbus.ch_out      = {$urandom, $urandom};
            dbus.ch_out_vld  = gaps ? {$urandom, $urandom} : 64'd0;
            dbus.ch_out_done = '0;
            if ($onehot(cur_en)) begin
                c = 0;
                for (int k = 0; k < 64; k++) if (cur_en[k]) c = k;
                dbus.ch_out_vld[c] = 1'b0;
                if (!dsent[c]) begin
                    if (pos[c] < len_a[c]) begin
                        if (!gaps || $urandom_range(3) != 0) begin
                            dbus.ch_out_vld[c] = 1'b1;
                            dbus.ch_out[c]     = bits_a[c][pos[c]];
                            pos[c]++;
                            if (pos[c] == len_a[c] && tog_a[c]) begin
                                dbus.ch_out_done[c] = 1'b1;
                                dsent[c] = 1'b1;
                                post = 2;
                            end
                        end
                    end else begin
                        dbus.ch_out_done[c] = 1'b1;
                        dsent[c] = 1'b1;
                        post = 2;
                    end
                    if (dsent[c]) begin
                        post_en = '0;
                        for (int k = 63; k > c; k--) if (mask[k]) post_en = 64'd1 << k;
                    end
                end
            end
            step();
            ncyc++;
        end
        dbus.ch_out_vld  = '0;
        dbus.ch_out_done = '0;
        checks++;
        if (ndone != 1) begin
            $display("FAIL campaign_timeout done_seen=%0d want 1 within %0d cycles", ndone, LIMIT);
            errors++;
        end
        checks++;
        if (exp_ch.size() != 0) begin
            $display("FAIL stream_missing left=%0d want 0", exp_ch.size());
            errors++;
        end
        checks++;
        if (ncen != d + i + s || nerr != i) begin
            $display("FAIL dump_phase_counts c_en=%0d err_en=%0d want %0d %0d", ncen, nerr, d + i + s, i);
            errors++;
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbus.dump_vld !== 1'b0) begin
            $display("FAIL campaign_end busy=%b done=%b vld=%b want 0 0 0", busy, done, dbus.dump_vld);
            errors++;
        end
        cfg_mask = '0;
    endtask

    task automatic test_single_chain();
        clear_chains();
        len_a[5]  = 4;
        bits_a[5] = 8'b0000_1101;
        run_campaign(0, 0, 0, 2'd0, 64'h20, 1'b0);
    endtask

    task automatic test_multi_chain();
        clear_chains();
        foreach (len_a[k]) begin
            if (k == 0 || k == 3 || k == 63) begin
                len_a[k]  = $urandom_range(6, 1);
                bits_a[k] = 8'($urandom);
                tog_a[k]  = 1'($urandom_range(1));
            end
        end
        run_campaign(1, 1, 1, 2'd1, (64'd1 << 63) | 64'h9, 1'b1);
    endtask

    task automatic test_vld_done_together();
        clear_chains();
        len_a[7] = 3;  bits_a[7] = 8'b101; tog_a[7] = 1'b1;
        len_a[9] = 2;  bits_a[9] = 8'b10;  tog_a[9] = 1'b1;
        run_campaign(0, 2, 0, 2'd3, 64'h280, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] m;
        for (int r = 0; r < 4; r++) begin
            clear_chains();
            m = '0;
            for (int b = 0; b < 4; b++) m[$urandom_range(63)] = 1'b1;
            for (int k = 0; k < 64; k++) begin
                if (m[k]) begin
                    len_a[k]  = $urandom_range(5, 1);
                    bits_a[k] = 8'($urandom);
                    tog_a[k]  = 1'($urandom_range(1));
                end
            end
            run_campaign($urandom_range(3), $urandom_range(3), $urandom_range(3),
                         2'($urandom_range(3)), m, 1'b1);
        end
    endtask

    task automatic test_abort_reset();
        int n;
        logic [8:0] obs;
        clear_chains();
        cfg_delay = 16'd1; cfg_dur = 16'd5; cfg_settle = 16'd2; cfg_mode = 2'd3; cfg_mask = 64'h4;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (err_en !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (err_en !== 1'b1) begin
            $display("FAIL abort_reach_inject err_en=%b want 1", err_en);
            errors++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        obs = {err_en, err_ctrl, c_en, busy, done, dbus.dump_en != 0, dbus.dump_vld, 1'b0};
        checks++;
        if (obs !== 9'b0) begin
            $display("FAIL abort_outputs got %b want 0", obs);
            errors++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_quiet cyc=%0d done=%b busy=%b want 0 0", k, done, busy);
                errors++;
            end
            step();
        end
        cfg_delay = '0; cfg_dur = '0; cfg_settle = '0; cfg_mask = 64'h4;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (dbus.dump_en !== 64'h4 && n < 20) begin step(); n++; end
        checks++;
        if (dbus.dump_en !== 64'h4) begin
            $display("FAIL reset_reach_dump en=%h want 4", dbus.dump_en);
            errors++;
        end
        dbus.ch_out_vld[2] = 1'b1;
        dbus.ch_out[2]     = 1'b1;
        step();
        dbus.ch_out_vld = '0;
        checks++;
        if (dbus.dump_vld !== 1'b1 || dbus.dump_ch !== 6'd2) begin
            $display("FAIL reset_pre_bit vld=%b ch=%0d want 1 2", dbus.dump_vld, dbus.dump_ch);
            errors++;
        end
        rst_n = 1'b0;
        step();
        obs = {err_en, err_ctrl, c_en, busy, done, dbus.dump_en != 0, dbus.dump_vld, dbus.dump_bit};
        checks++;
        if (obs !== 9'b0) begin
            $display("FAIL reset_mid_dump got %b want 0", obs);
            errors++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL reset_quiet cyc=%0d done=%b busy=%b want 0 0", k, done, busy);
                errors++;
            end
        end
        cfg_mask = '0;
    endtask

    initial begin
        clear_chains();
        test_reset();
        test_phases(2, 3, 1, 2'd2, 1'b0);
        for (int r = 0; r < 4; r++)
            test_phases($urandom_range(4), $urandom_range(4), $urandom_range(4),
                        2'($urandom_range(3)), 1'b0);
        test_single_chain();
        test_multi_chain();
        test_vld_done_together();
        test_back_to_back();
        test_abort_reset();
        test_phases(3, 2, 2, 2'd1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/err_campaign_ctrl.md
ERR_CAMPAIGN_CTRL -- requirements
Module: err_campaign_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 64, meaning number of scan chains.
REQ-002 SHALL have parameter CW, default 16, meaning width of the phase-length counters.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port start  in  1  campaign start pulse; honoured only in IDLE.
REQ-006 SHALL have port abort  in  1  abandon the campaign from any state.
REQ-007 SHALL have port cfg_mode  in  2  err_ctrl value applied during injection.
REQ-008 SHALL have ports cfg_delay, cfg_dur and cfg_settle  in  CW  cycle counts for the DELAY, INJECT and SETTLE phases.
REQ-009 SHALL have port cfg_mask  in  NCH  chains to dump.
REQ-010 SHALL have ports err_en out 1, err_ctrl out 2 and c_en out 1, all driving the datapath under test.
REQ-011 SHALL have port dump_en  out  NCH  one-hot chain dump select.
REQ-012 SHALL have ports ch_out, ch_out_vld and ch_out_done, each in NCH, carrying the per-chain serial bit, bit-valid and chain-finished strobes.
REQ-013 SHALL have ports dump_bit out 1, dump_ch out log2(NCH) and dump_vld out 1, forming the merged dump stream.
REQ-014 SHALL have ports busy out 1 (not IDLE) and done out 1 (one-cycle completion pulse).

Function
REQ-015 SHALL implement the states IDLE, DELAY, INJECT, SETTLE, SELECT, DUMP and FIN.
REQ-016 SHALL, on start in IDLE, latch every cfg_* input into internal registers; cfg changes after that edge have no effect.
REQ-017 SHALL hold DELAY, INJECT and SETTLE for exactly the latched cycle count each; a count of 0 skips that phase with no idle cycle.
REQ-018 SHALL assert c_en=1 in DELAY, INJECT and SETTLE, and c_en=0 in every other state.
REQ-019 SHALL drive err_en=1 and err_ctrl=latched mode only in INJECT, with err_en=0 and err_ctrl=0 in all other states.
REQ-020 SHALL, in SELECT, pick the lowest set bit of the remaining mask, go to DUMP with that index, and go to FIN if the remaining mask is zero (this takes 1 cycle).
REQ-021 SHALL, in DUMP, drive dump_en one-hot at the selected index, with dump_en=0 in all other states.
REQ-022 SHALL, in DUMP, on ch_out_vld[idx], produce on the next cycle dump_vld=1, dump_bit=ch_out[idx] and dump_ch=idx (latency 1); vld on non-selected chains is ignored.
REQ-023 SHALL, in DUMP, on ch_out_done[idx], clear mask bit idx and return to SELECT; if vld and done fall in the same cycle, the bit is emitted before the move.
REQ-024 SHALL assert done for exactly one cycle in FIN, then return to IDLE.
REQ-025 SHALL, on abort in any non-IDLE state, return to IDLE on the next edge with all outputs deasserted and no done pulse; abort takes priority over all other events.
REQ-026 SHALL ignore start while busy=1.

Reset
REQ-027 SHALL, while rst_n=0, force the state to IDLE and drive err_en, err_ctrl, c_en, dump_en, dump_vld, dump_bit, dump_ch, busy and done to 0, clearing all latched config; reset mid-campaign aborts it silently.

Structure
REQ-028 SHALL place the state enum, NCH and CW defaults, and the phase-count type in the shared package err_inj_pkg.
REQ-029 SHALL implement the lowest-set-bit search in the sub-module err_pri_enc (NCH-bit input; index and any-set outputs, combinational).

Verification
REQ-030 SHALL test: delay=2, dur=3, settle=1, mode=2, mask=0 -> err_en high exactly 3 cycles with err_ctrl=2, c_en high 6 cycles, done 1 cycle later.
REQ-031 SHALL test: all counts 0 and mask=bit5 -> start goes straight to SELECT and DUMP with dump_en=0x20; 4 vld bits 1,0,1,1 then done -> dump_ch=5 stream 1,0,1,1 and a done pulse.
REQ-032 SHALL test: mask=bits 0,3,63 -> chains dumped in order 0,3,63, with dump_en never more than one-hot.
REQ-033 SHALL test: vld and done together on the last bit -> that bit is emitted, and the next chain is selected the cycle after.
REQ-034 SHALL test: abort during INJECT, then rst_n low during DUMP -> both outputs fall to 0 on the next edge, with no done pulse and busy=0.
REQ-035 SHALL test: start pulsed while busy and cfg changed mid-run -> no restart, and the original latched timing is preserved.
